// File: rtl/waveform_capture.sv
// waveform_capture: triggered, decimated 8-bit sample capture into a
// double-buffered line BRAM. The display reads bank disp_bank; this block
// fills the opposite bank and swaps banks only on a vsync rising edge.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   sample_in/valid/ready input sample stream (accept = valid && ready)
//   trig_level            rising-edge trigger threshold
//   decim                 keep 1 of every decim accepted samples (0 acts as 1)
//   vsync                 display vertical sync, level, active-high
//   bram_we/wr_adr/wr_data BRAM write port, wr_adr = {bank, index}
//   disp_bank             bank the display must read
//   frame_done            one-cycle pulse on bank swap
//   auto_trig             last displayed frame was captured via timeout
module waveform_capture #(
  parameter int unsigned WIDTH   = 1024,
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [7:0]        sample_in,
  input  logic              sample_valid,
  output logic              sample_ready,
  input  logic [7:0]        trig_level,
  input  logic [7:0]        decim,
  input  logic              vsync,
  output logic              bram_we,
  output logic [ADDR_W:0]   bram_wr_adr,
  output logic [7:0]        bram_wr_data,
  output logic              disp_bank,
  output logic              frame_done,
  output logic              auto_trig
);

  localparam int unsigned TCNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_ARM  = 2'd0,
    ST_FILL = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t              r_state, w_state_nxt;
  logic                r_ready, w_ready_nxt;
  logic                r_we, w_we_nxt;
  logic [ADDR_W:0]     r_adr, w_adr_nxt;
  logic [7:0]          r_data, w_data_nxt;
  logic                r_disp_bank, w_disp_bank_nxt;
  logic                r_frame_done, w_frame_done_nxt;
  logic                r_auto_trig, w_auto_trig_nxt;
  logic                r_auto_flag, w_auto_flag_nxt;
  logic [ADDR_W-1:0]   r_index, w_index_nxt;
  logic [7:0]          r_dcnt, w_dcnt_nxt;
  logic [7:0]          r_dmax, w_dmax_nxt;
  logic [TCNT_W-1:0]   r_tcnt, w_tcnt_nxt;
  logic [7:0]          r_prev, w_prev_nxt;
  logic                r_vs_q1, r_vs_q2;

  logic                w_accept;
  logic                w_vs_edge;
  logic                w_trig;
  logic                w_tmo;
  logic [7:0]          w_decim_eff;

  assign w_accept    = sample_valid && r_ready;
  assign w_vs_edge   = r_vs_q1 && !r_vs_q2;
  assign w_decim_eff = (decim == 8'd0) ? 8'd1 : decim;
  assign w_trig      = (r_prev < trig_level) && (sample_in >= trig_level);
  assign w_tmo       = (r_tcnt == TCNT_W'(TIMEOUT - 1));

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt      = r_state;
    w_we_nxt         = 1'b0;
    w_adr_nxt        = r_adr;
    w_data_nxt       = r_data;
    w_disp_bank_nxt  = r_disp_bank;
    w_frame_done_nxt = 1'b0;
    w_auto_trig_nxt  = r_auto_trig;
    w_auto_flag_nxt  = r_auto_flag;
    w_index_nxt      = r_index;
    w_dcnt_nxt       = r_dcnt;
    w_dmax_nxt       = r_dmax;
    w_tcnt_nxt       = r_tcnt;
    w_prev_nxt       = r_prev;

    case (r_state)
      ST_ARM: begin
        if (w_accept) begin
          w_prev_nxt = sample_in;
          if (r_tcnt != TCNT_W'(TIMEOUT)) begin
            w_tcnt_nxt = r_tcnt + TCNT_W'(1);
          end
          if (w_trig || w_tmo) begin
            // Trigger sample is stored at index 0 and counts as decimation slot 0.
            w_auto_flag_nxt = !w_trig;
            w_we_nxt        = 1'b1;
            w_adr_nxt       = {~r_disp_bank, ADDR_W'(0)};
            w_data_nxt      = sample_in;
            w_dmax_nxt      = w_decim_eff;
            w_dcnt_nxt      = (w_decim_eff == 8'd1) ? 8'd0 : 8'd1;
            if (WIDTH == 1) begin
              w_state_nxt = ST_HOLD;
            end else begin
              w_index_nxt = ADDR_W'(1);
              w_state_nxt = ST_FILL;
            end
          end
        end
      end

      ST_FILL: begin
        if (w_accept) begin
          if (r_dcnt == 8'd0) begin
            w_we_nxt   = 1'b1;
            w_adr_nxt  = {~r_disp_bank, r_index};
            w_data_nxt = sample_in;
            if (r_index == ADDR_W'(WIDTH - 1)) begin
              w_state_nxt = ST_HOLD;
            end else begin
              w_index_nxt = r_index + ADDR_W'(1);
            end
          end
          // New decim value is only picked up at the wrap.
          if (r_dcnt == r_dmax - 8'd1) begin
            w_dcnt_nxt = 8'd0;
            w_dmax_nxt = w_decim_eff;
          end else begin
            w_dcnt_nxt = r_dcnt + 8'd1;
          end
        end
      end

      ST_HOLD: begin
        if (w_vs_edge) begin
          w_disp_bank_nxt  = ~r_disp_bank;
          w_frame_done_nxt = 1'b1;
          w_auto_trig_nxt  = r_auto_flag;
          w_index_nxt      = '0;
          w_prev_nxt       = 8'd0;
          w_tcnt_nxt       = '0;
          w_state_nxt      = ST_ARM;
        end
      end

      default: begin
        w_state_nxt = ST_ARM;
      end
    endcase

    w_ready_nxt = (w_state_nxt != ST_HOLD);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_ARM;
      r_ready      <= 1'b1;
      r_we         <= 1'b0;
      r_adr        <= '0;
      r_data       <= 8'd0;
      r_disp_bank  <= 1'b0;
      r_frame_done <= 1'b0;
      r_auto_trig  <= 1'b0;
      r_auto_flag  <= 1'b0;
      r_index      <= '0;
      r_dcnt       <= 8'd0;
      r_dmax       <= 8'd1;
      r_tcnt       <= '0;
      r_prev       <= 8'd0;
      r_vs_q1      <= 1'b0;
      r_vs_q2      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_ready      <= w_ready_nxt;
      r_we         <= w_we_nxt;
      r_adr        <= w_adr_nxt;
      r_data       <= w_data_nxt;
      r_disp_bank  <= w_disp_bank_nxt;
      r_frame_done <= w_frame_done_nxt;
      r_auto_trig  <= w_auto_trig_nxt;
      r_auto_flag  <= w_auto_flag_nxt;
      r_index      <= w_index_nxt;
      r_dcnt       <= w_dcnt_nxt;
      r_dmax       <= w_dmax_nxt;
      r_tcnt       <= w_tcnt_nxt;
      r_prev       <= w_prev_nxt;
      r_vs_q1      <= vsync;
      r_vs_q2      <= r_vs_q1;
    end
  end

  assign sample_ready = r_ready;
  assign bram_we      = r_we;
  assign bram_wr_adr  = r_adr;
  assign bram_wr_data = r_data;
  assign disp_bank    = r_disp_bank;
  assign frame_done   = r_frame_done;
  assign auto_trig    = r_auto_trig;

endmodule

// File: tb/tb_waveform_capture.sv
// Scoreboard bench for waveform_capture: expected BRAM writes are queued by
// the stimulus, a negedge monitor pops and compares every write.
module tb_waveform_capture;
  localparam int unsigned WIDTH   = 1024;
  localparam int unsigned ADDR_W  = 10;
  localparam int unsigned TIMEOUT = 4096;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [7:0]        sample_in;
  logic              sample_valid;
  logic              sample_ready;
  logic [7:0]        trig_level;
  logic [7:0]        decim;
  logic              vsync;
  logic              bram_we;
  logic [ADDR_W:0]   bram_wr_adr;
  logic [7:0]        bram_wr_data;
  logic              disp_bank;
  logic              frame_done;
  logic              auto_trig;

  always #5 clk = ~clk;

  waveform_capture #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n),
    .sample_in(sample_in), .sample_valid(sample_valid), .sample_ready(sample_ready),
    .trig_level(trig_level), .decim(decim), .vsync(vsync),
    .bram_we(bram_we), .bram_wr_adr(bram_wr_adr), .bram_wr_data(bram_wr_data),
    .disp_bank(disp_bank), .frame_done(frame_done), .auto_trig(auto_trig)
  );

  typedef struct packed {
    logic [ADDR_W:0] adr;
    logic [7:0]      data;
  } wr_t;

  wr_t  exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   acc_cnt = 0, wr_cnt = 0, fd_cnt = 0, cyc = 0;
  int   idx0_acc = 0, idx0_cyc = 0, last_cyc = 0;
  logic prev_acc = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: compare each write against the scoreboard.
  always @(negedge clk) begin
    wr_t e;
    cyc++;
    if (frame_done) fd_cnt++;
    if (bram_we) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got adr=%0h data=%0d expected no write", bram_wr_adr, bram_wr_data);
      end else begin
        e = exp_q.pop_front();
        check("wr_adr", longint'(bram_wr_adr), longint'(e.adr));
        check("wr_data", longint'(bram_wr_data), longint'(e.data));
      end
      check("write_follows_accept", longint'(prev_acc), 1);
      wr_cnt++;
      if (bram_wr_adr[ADDR_W-1:0] == '0) begin
        idx0_acc = acc_cnt;
        idx0_cyc = cyc;
      end
      if (bram_wr_adr[ADDR_W-1:0] == ADDR_W'(WIDTH - 1)) last_cyc = cyc;
    end
    prev_acc = reset_n && sample_valid && sample_ready;
    if (prev_acc) acc_cnt++;
  end

  task automatic push_exp(input logic bank, input int n, input int step, input bit cnst);
    wr_t e;
    for (int i = 0; i < n; i++) begin
      e.adr  = {bank, ADDR_W'(i)};
      e.data = cnst ? 8'd50 : 8'(128 + i * step);
      exp_q.push_back(e);
    end
  endtask

  // Drive a ramp (or constant 50) until HOLD, or assert reset at stop_idx write.
  task automatic run_frame(input bit cnst, input bit toggle, input int stop_idx, input int budget);
    logic [7:0] v;
    bit w;
    bit done;
    v = 8'd0;
    done = 1'b0;
    sample_in = cnst ? 8'd50 : v;
    sample_valid = 1'b1;
    for (int n = 0; n < budget && !done; n++) begin
      @(negedge clk);
      w = sample_valid && sample_ready;
      @(posedge clk);
      #1;
      if (w && !cnst) v = v + 8'd1;
      sample_in = cnst ? 8'd50 : v;
      if (stop_idx >= 0 && bram_we && int'(bram_wr_adr[ADDR_W-1:0]) == stop_idx) begin
        reset_n = 1'b0;
        done = 1'b1;
      end else if (!sample_ready) begin
        done = 1'b1;
      end else if (toggle) begin
        sample_valid = ~sample_valid;
      end
    end
    sample_valid = 1'b0;
    check("frame_within_budget", longint'(done), 1);
  endtask

  task automatic do_vsync(input logic exp_bank, input logic exp_auto);
    int fd0;
    fd0 = fd_cnt;
    @(posedge clk); #1 vsync = 1'b1;
    @(posedge clk); #1 check("bank_before_swap", longint'(disp_bank), longint'(!exp_bank));
    @(posedge clk); #1;
    check("bank_after_swap", longint'(disp_bank), longint'(exp_bank));
    check("frame_done_pulse", longint'(frame_done), 1);
    check("auto_trig", longint'(auto_trig), longint'(exp_auto));
    repeat (4) @(posedge clk);
    #1 check("frame_done_count", fd_cnt - fd0, 1);
    vsync = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic settle_checks(input string tag, input int acc0, input int wr0,
                               input int exp_n, input int exp_first, input int exp_span);
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_queue_empty"}, exp_q.size(), 0);
    check({tag, "_write_count"}, wr_cnt - wr0, exp_n);
    check({tag, "_first_write_accept"}, idx0_acc - acc0, exp_first);
    check({tag, "_write_span"}, last_cyc - idx0_cyc, exp_span);
    check({tag, "_hold_not_ready"}, longint'(sample_ready), 0);
  endtask

  initial begin
    int acc0, wr0, fd0;
    reset_n = 1'b0;
    sample_in = 8'd0;
    sample_valid = 1'b0;
    trig_level = 8'd128;
    decim = 8'd1;
    vsync = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_we", longint'(bram_we), 0);
    check("rst_adr", longint'(bram_wr_adr), 0);
    check("rst_data", longint'(bram_wr_data), 0);
    check("rst_bank", longint'(disp_bank), 0);
    check("rst_frame_done", longint'(frame_done), 0);
    check("rst_auto", longint'(auto_trig), 0);
    check("rst_ready", longint'(sample_ready), 1);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Ramp, decim=1, writes bank 1.
    acc0 = acc_cnt; wr0 = wr_cnt;
    push_exp(1'b1, WIDTH, 1, 1'b0);
    run_frame(1'b0, 1'b0, -1, 2000);
    settle_checks("ramp1", acc0, wr0, WIDTH, 129, WIDTH - 1);
    check("ramp1_no_early_swap", longint'(disp_bank), 0);
    do_vsync(1'b1, 1'b0);

    // Ramp, decim=4, vsync held high throughout; writes bank 0.
    decim = 8'd4;
    vsync = 1'b1;
    acc0 = acc_cnt; wr0 = wr_cnt; fd0 = fd_cnt;
    push_exp(1'b0, WIDTH, 4, 1'b0);
    run_frame(1'b0, 1'b0, -1, 6000);
    settle_checks("ramp4", acc0, wr0, WIDTH, 129, 4 * (WIDTH - 1));
    repeat (10) @(posedge clk);
    #1;
    check("held_vsync_no_swap", longint'(disp_bank), 1);
    check("held_vsync_no_pulse", fd_cnt - fd0, 0);
    vsync = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    do_vsync(1'b0, 1'b0);

    // Constant 50 never crosses 128: timeout trigger; decim=0 behaves as 1.
    decim = 8'd0;
    acc0 = acc_cnt; wr0 = wr_cnt;
    push_exp(1'b1, WIDTH, 0, 1'b1);
    run_frame(1'b1, 1'b0, -1, 6000);
    settle_checks("timeout", acc0, wr0, WIDTH, TIMEOUT, WIDTH - 1);
    do_vsync(1'b1, 1'b1);

    // Reset while index 500 is being written: only 0..499 land.
    decim = 8'd1;
    wr0 = wr_cnt;
    push_exp(1'b0, 500, 1, 1'b0);
    run_frame(1'b0, 1'b0, 500, 2000);
    #1;
    check("midreset_we_low", longint'(bram_we), 0);
    check("midreset_bank0", longint'(disp_bank), 0);
    check("midreset_ready", longint'(sample_ready), 1);
    check("midreset_auto_clear", longint'(auto_trig), 0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
    check("midreset_queue_empty", exp_q.size(), 0);
    check("midreset_write_count", wr_cnt - wr0, 500);

    // Toggling valid: same contents, stretched by 2; writes bank 1.
    acc0 = acc_cnt; wr0 = wr_cnt;
    push_exp(1'b1, WIDTH, 1, 1'b0);
    run_frame(1'b0, 1'b1, -1, 3000);
    settle_checks("toggle", acc0, wr0, WIDTH, 129, 2 * (WIDTH - 1));
    do_vsync(1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
